// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the Memory stage: word/byte loads and stores
// with LATENCY wait states and a stall request to the hazard unit; LATENCY=0 is pass-through.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        MemDoneM
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  logic [31:0]   mem [DEPTH];
  logic          req;
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_wdata;
  logic          unused_addr;

  assign req         = MemReadM | MemWriteM;
  assign unused_addr = ^AddrM[31:AW+2];

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic byte_acc,
                                           input logic [1:0] lane);
    if (byte_acc) return {24'd0, word[{lane, 3'b000} +: 8]};
    return word;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic byte_acc, input logic [1:0] lane);
    logic [31:0] res;
    res = wdata;
    if (byte_acc) begin
      res = word;
      res[{lane, 3'b000} +: 8] = wdata[7:0];
    end
    return res;
  endfunction

  // Storage array: never reset, so committed stores survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  if (LATENCY == 0) begin : g_pass
    assign mem_idx   = AddrM[AW+1:2];
    assign mem_we    = MemWriteM & ~reset;
    assign mem_wdata = store_val(mem[mem_idx], WriteDataM, ByteM, AddrM[1:0]);
    assign ReadDataM = load_val(mem[mem_idx], ByteM, AddrM[1:0]);
    assign MemStallM = 1'b0;
    assign MemDoneM  = req;
  end else begin : g_fsm
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          commit;
    logic [AW-1:0] idx_q, idx_s;
    logic [1:0]    lane_q, lane_s;
    logic          byte_q, byte_s;
    logic          write_q, write_s;
    logic [31:0]   wdata_q, wdata_s;

    // Live inputs in the accept cycle (needed when LATENCY=1), latched copies afterwards.
    always_comb begin
      if (state == S_IDLE) begin
        idx_s   = AddrM[AW+1:2];
        lane_s  = AddrM[1:0];
        byte_s  = ByteM;
        write_s = MemWriteM;
        wdata_s = WriteDataM;
      end else begin
        idx_s   = idx_q;
        lane_s  = lane_q;
        byte_s  = byte_q;
        write_s = write_q;
        wdata_s = wdata_q;
      end
    end

    always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      commit    = 1'b0;
      MemStallM = 1'b0;
      MemDoneM  = 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            MemStallM = 1'b1;
            if (LATENCY == 1) begin
              state_nx = S_RESP;
              cnt_nx   = '0;
              commit   = 1'b1;
            end else begin
              state_nx = S_WAIT;
              cnt_nx   = CW'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          MemStallM = 1'b1;
          cnt_nx    = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nx = S_RESP;
            commit   = 1'b1;
          end
        end
        S_RESP: begin
          MemDoneM = 1'b1;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    assign mem_idx   = idx_s;
    assign mem_we    = commit & write_s & ~reset;
    assign mem_wdata = store_val(mem[idx_s], wdata_s, byte_s, lane_s);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= S_IDLE;
        cnt       <= '0;
        ReadDataM <= '0;
        idx_q     <= '0;
        lane_q    <= '0;
        byte_q    <= 1'b0;
        write_q   <= 1'b0;
        wdata_q   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        if (state == S_IDLE && req) begin
          idx_q   <= AddrM[AW+1:2];
          lane_q  <= AddrM[1:0];
          byte_q  <= ByteM;
          write_q <= MemWriteM;
          wdata_q <= WriteDataM;
        end
        if (commit && !write_s) ReadDataM <= load_val(mem[idx_s], byte_s, lane_s);
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: five responders (LATENCY 0..4) driven by directed tables,
// hand-written reset sequences and random traffic checked against a word-array model.
module tb_dmem_responder;

  localparam int NI    = 5;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_i  [NI];
  logic        wr_i  [NI];
  logic        by_i  [NI];
  logic [31:0] ad_i  [NI];
  logic [31:0] wd_i  [NI];
  logic [31:0] rdata [NI];
  logic        stall [NI];
  logic        done  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(.DEPTH(DEPTH), .LATENCY(g)) u_dut (
      .clk(clk), .reset(reset),
      .MemReadM(rd_i[g]), .MemWriteM(wr_i[g]), .ByteM(by_i[g]),
      .AddrM(ad_i[g]), .WriteDataM(wd_i[g]),
      .ReadDataM(rdata[g]), .MemStallM(stall[g]), .MemDoneM(done[g])
    );
  end

  // Reference: one word array per instance plus the last load value each responder returned.
  logic [31:0] mdl  [NI][DEPTH];
  logic [31:0] rexp [NI];
  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s (latency %0d): got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_load(input int k, input bit by, input logic [31:0] addr);
    int unsigned i  = (addr / 4) % DEPTH;
    int unsigned sh = (addr % 4) * 8;
    if (by) return (mdl[k][i] >> sh) & 32'hFF;
    return mdl[k][i];
  endfunction

  task automatic mdl_store(input int k, input bit by, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned i  = (addr / 4) % DEPTH;
    int unsigned sh = (addr % 4) * 8;
    if (by) mdl[k][i] = (mdl[k][i] & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
    else    mdl[k][i] = wdata;
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    rd_i[k] = 1'b0; wr_i[k] = 1'b0;
    #1;
    chk("idle_stall", k, 32'(stall[k]), 32'd0);
    chk("idle_done", k, 32'(done[k]), 32'd0);
  endtask

  // One access held by the pipeline until its response cycle; checks every cycle.
  task automatic do_access(input int k, input bit rd, input bit wr, input bit by,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] got);
    logic [31:0] exp_r;
    @(negedge clk);
    rd_i[k] = rd; wr_i[k] = wr; by_i[k] = by; ad_i[k] = addr; wd_i[k] = wdata;
    exp_r = wr ? rexp[k] : mdl_load(k, by, addr);
    got = 'x;
    if (k == 0) begin
      #1;
      chk("pass_stall", k, 32'(stall[k]), 32'd0);
      chk("pass_done", k, 32'(done[k]), 32'd1);
      if (!wr) chk("pass_rdata", k, rdata[k], exp_r);
      got = rdata[k];
    end else begin
      for (int c = 0; c <= k; c++) begin
        if (c > 0) begin
          @(negedge clk);
          by_i[k] = 1'($urandom); ad_i[k] = $urandom; wd_i[k] = $urandom;
        end
        #1;
        chk("stall", k, 32'(stall[k]), (c < k) ? 32'd1 : 32'd0);
        chk("done", k, 32'(done[k]), (c == k) ? 32'd1 : 32'd0);
        if (c == k) begin
          chk("rdata", k, rdata[k], exp_r);
          got = rdata[k];
        end
      end
    end
    if (wr) mdl_store(k, by, addr, wdata);
    else if (k != 0) rexp[k] = exp_r;
  endtask

  typedef struct {
    int          k;
    bit          rd, wr, by;
    logic [31:0] addr, wdata;
    bit          has_exp;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [25];

  initial begin
    logic [31:0] got;
    int          op;

    tbl = '{
      '{2, 0, 1, 0, 32'h10,  32'hDEADBEEF, 0, 32'h0},
      '{2, 1, 0, 0, 32'h10,  32'h0,        1, 32'hDEADBEEF},
      '{2, 0, 1, 0, 32'h20,  32'h11223344, 0, 32'h0},
      '{2, 0, 1, 1, 32'h22,  32'h000000AA, 0, 32'h0},
      '{2, 1, 0, 0, 32'h20,  32'h0,        1, 32'h11AA3344},
      '{2, 1, 0, 1, 32'h23,  32'h0,        1, 32'h00000011},
      '{2, 0, 1, 0, 32'h104, 32'hCAFEF00D, 0, 32'h0},
      '{2, 1, 0, 0, 32'h004, 32'h0,        1, 32'hCAFEF00D},
      '{2, 1, 1, 0, 32'h30,  32'h0BADF00D, 1, 32'hCAFEF00D},
      '{2, 1, 0, 0, 32'h30,  32'h0,        1, 32'h0BADF00D},
      '{3, 0, 1, 0, 32'h40,  32'h00000001, 0, 32'h0},
      '{3, 0, 1, 0, 32'h44,  32'h00000002, 0, 32'h0},
      '{3, 0, 1, 0, 32'h48,  32'h00000003, 0, 32'h0},
      '{3, 1, 0, 0, 32'h40,  32'h0,        1, 32'h00000001},
      '{3, 1, 0, 0, 32'h44,  32'h0,        1, 32'h00000002},
      '{3, 1, 0, 0, 32'h48,  32'h0,        1, 32'h00000003},
      '{0, 0, 1, 0, 32'h3C,  32'h12345678, 0, 32'h0},
      '{0, 1, 0, 0, 32'h3C,  32'h0,        1, 32'h12345678},
      '{0, 1, 0, 1, 32'h3D,  32'h0,        1, 32'h00000056},
      '{1, 0, 1, 0, 32'h0,   32'h89ABCDEF, 0, 32'h0},
      '{1, 0, 1, 1, 32'h3,   32'h00000012, 0, 32'h0},
      '{1, 1, 0, 0, 32'h0,   32'h0,        1, 32'h12ABCDEF},
      '{1, 1, 0, 1, 32'h1,   32'h0,        1, 32'h000000CD},
      '{4, 0, 1, 0, 32'h08,  32'h0000A5A5, 0, 32'h0},
      '{4, 1, 0, 0, 32'h08,  32'h0,        1, 32'h0000A5A5}
    };

    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      rd_i[k] = 1'b0; wr_i[k] = 1'b0; by_i[k] = 1'b0; ad_i[k] = '0; wd_i[k] = '0;
      rexp[k] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_stall", k, 32'(stall[k]), 32'd0);
      if (k > 0) begin
        chk("rst_done", k, 32'(done[k]), 32'd0);
        chk("rst_rdata", k, rdata[k], 32'd0);
      end
    end
    @(negedge clk);
    reset = 1'b0;

    // Fill every word so the model knows all contents
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < DEPTH; i++) do_access(k, 1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom, got);
      idle(k);
    end

    // Directed table; consecutive entries on one instance run back-to-back
    for (int i = 0; i < $size(tbl); i++) begin
      do_access(tbl[i].k, tbl[i].rd, tbl[i].wr, tbl[i].by, tbl[i].addr, tbl[i].wdata, got);
      if (tbl[i].has_exp) chk($sformatf("tbl%0d", i), tbl[i].k, got, tbl[i].exp);
      if (i == $size(tbl) - 1 || tbl[i + 1].k != tbl[i].k) idle(tbl[i].k);
    end

    // Reset during WAIT aborts the uncommitted store
    @(negedge clk);
    rd_i[4] = 1'b0; wr_i[4] = 1'b1; by_i[4] = 1'b0; ad_i[4] = 32'h08; wd_i[4] = 32'h55;
    #1;
    chk("abort_accept_stall", 4, 32'(stall[4]), 32'd1);
    @(negedge clk);
    #1;
    chk("abort_wait1_stall", 4, 32'(stall[4]), 32'd1);
    @(negedge clk);
    reset = 1'b1; wr_i[4] = 1'b0;
    #1;
    chk("abort_stall", 4, 32'(stall[4]), 32'd0);
    chk("abort_done", 4, 32'(done[4]), 32'd0);
    for (int k = 1; k < NI; k++) chk("abort_rdata", k, rdata[k], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NI; k++) rexp[k] = '0;
    do_access(4, 1'b1, 1'b0, 1'b0, 32'h08, 32'h0, got);
    chk("abort_old_data", 4, got, 32'h0000A5A5);
    idle(4);

    // Reset released in the same cycle a request appears
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_i[2] = 1'b1; wr_i[2] = 1'b0; by_i[2] = 1'b0; ad_i[2] = 32'h10;
    #1;
    chk("rel_accept_stall", 2, 32'(stall[2]), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("rel_done", 2, 32'(done[2]), 32'd1);
    chk("rel_rdata", 2, rdata[2], 32'hDEADBEEF);
    for (int k = 0; k < NI; k++) rexp[k] = '0;
    rexp[2] = 32'hDEADBEEF;
    idle(2);

    // Random traffic with full 32-bit addresses and idle gaps
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 40; n++) begin
        op = int'($urandom_range(0, 2));
        do_access(k, op != 1, op != 0, 1'($urandom), $urandom, $urandom, got);
        if ($urandom_range(0, 2) == 0) idle(k);
      end
      idle(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipeline's Memory stage. It serves the load and store requests the datapath issues: the address (ALUOutM) and the store data (WriteDataM). It returns ReadDataM after a configurable number of wait states. While an access is in flight it raises a stall request to the hazard unit, so the whole pipeline holds until the response cycle.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, at least 4.
- LATENCY, 2: response latency in cycles, range 0–15; 0 selects zero-wait pass-through mode.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all control state.
- MemReadM  input  1  load request.
- MemWriteM  input  1  store request.
- ByteM  input  1  1 = byte access, 0 = word access.
- AddrM  input  32  byte address (ALUOutM).
- WriteDataM  input  32  store data; byte stores use bits [7:0].
- ReadDataM  output  32  load data.
- MemStallM  output  1  stall request to the hazard unit.
- MemDoneM  output  1  one-cycle pulse marking the response cycle.

## Operation
- Request: req = MemReadM | MemWriteM. If both are set, the access is treated as a store.
- Word index = AddrM[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo 4·DEPTH.
- Word access ignores AddrM[1:0].
- Byte access uses lane AddrM[1:0]: lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Byte loads zero-extend.
  - Byte stores modify only the selected lane.
- FSM, for LATENCY ≥ 1: IDLE, WAIT, RESP.
  - IDLE with req: latch addr, wdata, ByteM and the write flag; load counter = LATENCY−1. Go to WAIT, or to RESP if LATENCY = 1.
  - IDLE without req: stay in IDLE.
  - WAIT: decrement the counter; when it reaches 0, go to RESP. On that edge, commit the store to memory, or register the load data into ReadDataM.
  - RESP: always go to IDLE. The pipeline advances on this edge, and the next instruction's request is evaluated in IDLE on the following cycle.
- MemStallM = (IDLE & req) | WAIT. It is combinational in IDLE, because the pipeline must hold in the accept cycle. It is deasserted in RESP.
- MemDoneM = 1 only in RESP.
- ReadDataM:
  - Updates only on load completion; it holds its value through stores and idle cycles.
  - After a store, ReadDataM keeps the previous load value.
- Input changes after acceptance are ignored; the latched copies are used.
- LATENCY = 0:
  - No FSM, and MemStallM is tied to 0.
  - ReadDataM is a combinational read of the addressed word, with lane select and zero-extension.
  - Stores write on the rising edge while req is high.
  - MemDoneM = req.
- Memory array:
  - Uninitialised, and not cleared by reset.
  - Store data is committed only on the edge entering RESP.
- Reset, asynchronous:
  - State returns to IDLE and the counter to 0.
  - ReadDataM = 0, MemDoneM = 0; MemStallM = 0 while no req is present.
  - A store that has not yet committed is aborted and memory is unchanged. A committed store survives reset.

## Timing
- With LATENCY = L ≥ 1, a request arriving in cycle 0:
  - MemStallM = 1 in cycles 0…L−1.
  - Cycle L is RESP: MemStallM = 0, MemDoneM = 1, ReadDataM valid.
  - Total L stall cycles and an occupancy of L+1 cycles per access.
- Back-to-back memory instructions:
  - The second request is accepted in the cycle after RESP.
  - No request is lost or accepted twice.
  - The response cycle of one access never overlaps the accept cycle of the next.
- A store followed by a load to the same address returns the new data: the store commits before the load is accepted.
- Reset deasserted in the same cycle as a request: the request is accepted on the first clock edge after reset falls.

## Test plan
- Word store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 → MemStallM high for 2 cycles, MemDoneM pulses in cycle 2.
  - Load from 0x10 → ReadDataM = 0xDEADBEEF in its RESP cycle.
- Byte lanes, word at 0x20 = 0x11223344:
  - Byte store 0xAA to 0x22 → word = 0x11AA3344.
  - Byte load from 0x23 → ReadDataM = 0x00000011.
- Aliasing and simultaneous flags, DEPTH=64:
  - Store to 0x104 → visible by a load from 0x004.
  - MemReadM = MemWriteM = 1 → the access is a store, and ReadDataM is unchanged.
- Back-to-back, LATENCY=3:
  - Three consecutive loads held steady under stall → exactly 3 MemDoneM pulses, 4 cycles apart, each with the correct data.
- Reset mid-store, LATENCY=4:
  - Store 0x55 to 0x08; assert reset in WAIT cycle 2 → FSM in IDLE, MemStallM = 0, ReadDataM = 0.
  - A later load from 0x08 returns the old content.
- LATENCY=0:
  - Store then load 0x12345678 at 0x3C → MemStallM is never asserted.
  - ReadDataM is valid in the same cycle as the load request.
